// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single line-oriented memory port.
// One transaction at a time: IDLE picks a winner, BUSY drives memory, DONE pulses completion.
module mem_arbiter #(
    parameter int RISC_data = 32,
    parameter int main_data = 128,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 RST,

    input  logic                 req0_RE,
    input  logic                 req0_WE,
    input  logic [9:0]           req0_A,
    input  logic [RISC_data-1:0] req0_WD,
    output logic                 req0_done,
    output logic                 req0_err,
    output logic [main_data-1:0] req0_RD,

    input  logic                 req1_RE,
    input  logic                 req1_WE,
    input  logic [9:0]           req1_A,
    input  logic [RISC_data-1:0] req1_WD,
    output logic                 req1_done,
    output logic                 req1_err,
    output logic [main_data-1:0] req1_RD,

    output logic                 mem_RE,
    output logic                 mem_WE,
    output logic [7:0]           mem_A,
    output logic [1:0]           mem_word_loc,
    output logic [RISC_data-1:0] mem_WD,
    input  logic                 mem_done,
    input  logic [main_data-1:0] mem_RD,

    output logic                 busy,
    output logic [1:0]           grant,
    output logic [1:0]           dbg_state
);

    // Handshake: a requester is "valid" while RE or WE is high and must hold RE/WE/A/WD
    // stable until it samples reqn_done; reqn_done acts as the one-cycle "ready/accept".
    // On the memory side the strobe is "valid" and mem_done is "ready"; the strobe drops
    // on the edge that samples mem_done.

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_n;
    logic                  owner, owner_n;
    logic                  op_wr, op_wr_n;
    logic                  ptr, ptr_n;
    logic [CW-1:0]         cnt, cnt_n;

    logic                  mem_re_n, mem_we_n;
    logic [7:0]            mem_a_n;
    logic [1:0]            mem_wl_n;
    logic [RISC_data-1:0]  mem_wd_n;
    logic                  done0_n, done1_n, err0_n, err1_n;
    logic [main_data-1:0]  rd0_n, rd1_n;
    logic                  busy_n;
    logic [1:0]            grant_n;

    logic                  pend0, pend1, win;

    assign pend0 = req0_RE | req0_WE;
    assign pend1 = req1_RE | req1_WE;
    // Pointer only matters on a tie; a lone requester always wins.
    assign win   = (pend0 & pend1) ? ptr : pend1;

    assign dbg_state = state;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        op_wr_n  = op_wr;
        ptr_n    = ptr;
        cnt_n    = cnt;
        mem_re_n = mem_RE;
        mem_we_n = mem_WE;
        mem_a_n  = mem_A;
        mem_wl_n = mem_word_loc;
        mem_wd_n = mem_WD;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        err0_n   = 1'b0;
        err1_n   = 1'b0;
        rd0_n    = req0_RD;
        rd1_n    = req1_RD;
        busy_n   = busy;
        grant_n  = grant;

        case (state)
            IDLE: begin
                if (pend0 | pend1) begin
                    owner_n  = win;
                    op_wr_n  = win ? req1_WE : req0_WE;
                    mem_re_n = ~op_wr_n;
                    mem_we_n = op_wr_n;
                    mem_a_n  = win ? req1_A[9:2] : req0_A[9:2];
                    mem_wl_n = win ? req1_A[1:0] : req0_A[1:0];
                    mem_wd_n = win ? req1_WD : req0_WD;
                    cnt_n    = '0;
                    grant_n  = win ? 2'b10 : 2'b01;
                    busy_n   = 1'b1;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                // mem_done wins over a coincident timeout.
                if (mem_done) begin
                    mem_re_n = 1'b0;
                    mem_we_n = 1'b0;
                    state_n  = DONE;
                    if (owner) begin
                        done1_n = 1'b1;
                        if (!op_wr) rd1_n = mem_RD;
                    end else begin
                        done0_n = 1'b1;
                        if (!op_wr) rd0_n = mem_RD;
                    end
                end else if (cnt == CNT_MAX) begin
                    mem_re_n = 1'b0;
                    mem_we_n = 1'b0;
                    state_n  = DONE;
                    if (owner) begin
                        done1_n = 1'b1;
                        err1_n  = 1'b1;
                    end else begin
                        done0_n = 1'b1;
                        err0_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = 2'b00;
                busy_n  = 1'b0;
                ptr_n   = ~owner;
            end
            default: begin
                state_n  = IDLE;
                mem_re_n = 1'b0;
                mem_we_n = 1'b0;
                grant_n  = 2'b00;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            owner        <= 1'b0;
            op_wr        <= 1'b0;
            ptr          <= 1'b0;
            cnt          <= '0;
            mem_RE       <= 1'b0;
            mem_WE       <= 1'b0;
            mem_A        <= '0;
            mem_word_loc <= '0;
            mem_WD       <= '0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            req0_err     <= 1'b0;
            req1_err     <= 1'b0;
            req0_RD      <= '0;
            req1_RD      <= '0;
            busy         <= 1'b0;
            grant        <= 2'b00;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            op_wr        <= op_wr_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            mem_RE       <= mem_re_n;
            mem_WE       <= mem_we_n;
            mem_A        <= mem_a_n;
            mem_word_loc <= mem_wl_n;
            mem_WD       <= mem_wd_n;
            req0_done    <= done0_n;
            req1_done    <= done1_n;
            req0_err     <= err0_n;
            req1_err     <= err1_n;
            req0_RD      <= rd0_n;
            req1_RD      <= rd1_n;
            busy         <= busy_n;
            grant        <= grant_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of round-robin service, memory latency,
// timeout and read-line capture, driven with directed and randomized requests.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int LW = 128;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          RST;
    logic          req0_RE, req0_WE, req1_RE, req1_WE;
    logic [9:0]    req0_A, req1_A;
    logic [DW-1:0] req0_WD, req1_WD;
    logic          req0_done, req0_err, req1_done, req1_err;
    logic [LW-1:0] req0_RD, req1_RD;
    logic          mem_RE, mem_WE, mem_done;
    logic [7:0]    mem_A;
    logic [1:0]    mem_word_loc;
    logic [DW-1:0] mem_WD;
    logic [LW-1:0] mem_RD;
    logic          busy;
    logic [1:0]    grant;
    logic [1:0]    dbg_state;

    mem_arbiter #(.RISC_data(DW), .main_data(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .RST(RST),
        .req0_RE(req0_RE), .req0_WE(req0_WE), .req0_A(req0_A), .req0_WD(req0_WD),
        .req0_done(req0_done), .req0_err(req0_err), .req0_RD(req0_RD),
        .req1_RE(req1_RE), .req1_WE(req1_WE), .req1_A(req1_A), .req1_WD(req1_WD),
        .req1_done(req1_done), .req1_err(req1_err), .req1_RD(req1_RD),
        .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_A(mem_A), .mem_word_loc(mem_word_loc),
        .mem_WD(mem_WD), .mem_done(mem_done), .mem_RD(mem_RD),
        .busy(busy), .grant(grant), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state: requester intentions, expected captured lines, round-robin pointer
    logic          re_m[2];
    logic          we_m[2];
    logic [9:0]    a_m[2];
    logic [DW-1:0] wd_m[2];
    logic [LW-1:0] exp_rd[2];
    int            ptr_m;
    logic [1:0]    exp_q[$];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic drive_reqs();
        req0_RE = re_m[0]; req0_WE = we_m[0]; req0_A = a_m[0]; req0_WD = wd_m[0];
        req1_RE = re_m[1]; req1_WE = we_m[1]; req1_A = a_m[1]; req1_WD = wd_m[1];
    endtask

    task automatic clear_reqs();
        for (int n = 0; n < 2; n++) begin
            re_m[n] = 1'b0; we_m[n] = 1'b0; a_m[n] = '0; wd_m[n] = '0;
        end
        drive_reqs();
    endtask

    task automatic new_req(input int n);
        int kind;
        kind    = $urandom_range(0, 2);
        re_m[n] = (kind != 1);
        we_m[n] = (kind != 0);
        a_m[n]  = 10'($urandom());
        wd_m[n] = $urandom();
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        mem_done = 1'b0;
        mem_RD = '0;
        clear_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        ptr_m = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Starts from an IDLE-cycle negedge with requests in the model; ends at the next IDLE negedge.
    task automatic serve(input int delay, input bit to, input logic [LW-1:0] rdata,
                         input bit hold, input bit extra, output logic [1:0] g_obs);
        bit p0, p1, wr;
        int w, cycles;
        logic [1:0] gexp, sexp;
        p0 = re_m[0] | we_m[0];
        p1 = re_m[1] | we_m[1];
        w = (p0 && p1) ? ptr_m : (p1 ? 1 : 0);
        wr = we_m[w];
        gexp = (w == 1) ? 2'b10 : 2'b01;
        sexp = wr ? 2'b01 : 2'b10;
        drive_reqs();
        mem_done = 1'($urandom_range(0, 1));
        mem_RD = rand_line();
        @(posedge clk); @(negedge clk);
        mem_done = 1'b0;
        mem_RD = rand_line();
        g_obs = grant;
        check("busy_on", busy, 1);
        check("grant", grant, gexp);
        check("mem_A", mem_A, a_m[w][9:2]);
        check("mem_word_loc", mem_word_loc, a_m[w][1:0]);
        check("mem_WD", mem_WD, wd_m[w]);
        if (extra && !(re_m[1-w] | we_m[1-w])) begin
            new_req(1 - w);
            drive_reqs();
        end
        cycles = to ? TO : delay;
        for (int i = 1; i <= cycles; i++) begin
            check("strobe_hold", {mem_RE, mem_WE}, sexp);
            check("done_low", {req1_done, req0_done}, 0);
            if (!to && i == cycles) begin
                mem_done = 1'b1;
                mem_RD = rdata;
            end
            @(posedge clk); @(negedge clk);
            mem_done = 1'b0;
            mem_RD = rand_line();
        end
        check("strobe_drop", {mem_RE, mem_WE}, 0);
        check("done_pulse", {req1_done, req0_done}, gexp);
        check("err_flag", {req1_err, req0_err}, to ? gexp : 2'b00);
        check("busy_done", busy, 1);
        check("grant_done", grant, gexp);
        if (!wr && !to) exp_rd[w] = rdata;
        check("rd0", req0_RD, exp_rd[0]);
        check("rd1", req1_RD, exp_rd[1]);
        if (!hold) begin
            re_m[w] = 1'b0;
            we_m[w] = 1'b0;
        end
        drive_reqs();
        ptr_m = 1 - w;
        mem_done = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        mem_done = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
        check("idle_done", {req1_done, req0_done, req1_err, req0_err}, 0);
        check("idle_strobe", {mem_RE, mem_WE}, 0);
        check("idle_rd0", req0_RD, exp_rd[0]);
        check("idle_rd1", req1_RD, exp_rd[1]);
    endtask

    initial begin
        logic [1:0] g;
        int delay, k, pick;
        bit to;

        reset_dut();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_strobe", {mem_RE, mem_WE}, 0);
        check("rst_mem_A", {mem_A, mem_word_loc}, 0);
        check("rst_mem_WD", mem_WD, 0);
        check("rst_done", {req1_done, req0_done, req1_err, req0_err}, 0);
        check("rst_rd0", req0_RD, 0);
        check("rst_rd1", req1_RD, 0);

        // single read of block B1
        re_m[0] = 1'b1; a_m[0] = 10'h2C4;
        serve(3, 0, {4{32'hA5A5A5A5}}, 0, 0, g);
        check("read_line", req0_RD, {4{32'hA5A5A5A5}});

        // word write
        we_m[1] = 1'b1; a_m[1] = 10'h00E; wd_m[1] = 32'hDEADBEEF;
        serve(2, 0, rand_line(), 0, 0, g);
        check("write_rd1_unchanged", req1_RD, 0);

        // contention out of reset, both requests held across service
        reset_dut();
        re_m[0] = 1'b1; a_m[0] = 10'($urandom());
        we_m[1] = 1'b1; a_m[1] = 10'($urandom()); wd_m[1] = $urandom();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        for (int t = 0; t < 4; t++) begin
            serve($urandom_range(1, 4), 0, rand_line(), 1, 0, g);
            check("rr_grant", g, exp_q.pop_front());
        end
        clear_reqs();

        // timeout on a read
        re_m[0] = 1'b1; a_m[0] = 10'($urandom());
        serve(0, 1, rand_line(), 0, 0, g);

        // reset in the second BUSY cycle, late mem_done afterwards
        re_m[0] = 1'b1; a_m[0] = 10'($urandom());
        drive_reqs();
        @(posedge clk); @(negedge clk);
        check("rb_strobe", mem_RE, 1);
        @(posedge clk); @(negedge clk);
        RST = 1'b1;
        @(posedge clk); @(negedge clk);
        RST = 1'b0;
        clear_reqs();
        ptr_m = 0; exp_rd[0] = '0; exp_rd[1] = '0;
        check("rb_strobe_off", mem_RE, 0);
        check("rb_busy", busy, 0);
        check("rb_grant", grant, 0);
        check("rb_done", {req1_done, req0_done}, 0);
        mem_done = 1'b1; mem_RD = rand_line();
        @(posedge clk); @(negedge clk);
        mem_done = 1'b0;
        check("rb_late_done", {req1_done, req0_done}, 0);
        check("rb_late_busy", busy, 0);
        check("rb_late_rd0", req0_RD, 0);

        // randomized traffic, including coincident mem_done/timeout
        for (int t = 0; t < 40; t++) begin
            for (int n = 0; n < 2; n++)
                if (!(re_m[n] | we_m[n]) && $urandom_range(0, 1) == 1) new_req(n);
            if (!(re_m[0] | we_m[0] | re_m[1] | we_m[1])) begin
                pick = $urandom_range(0, 1);
                new_req(pick);
            end
            delay = $urandom_range(1, 8);
            to = 1'b0;
            k = $urandom_range(0, 9);
            if (k == 0) to = 1'b1;
            if (k == 1) delay = TO;
            serve(delay, to, rand_line(), 0, 1, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: RISC_data, default 32, write-word width; main_data, default 128, line width; TIMEOUT, default 64, maximum BUSY cycles before abort.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-003 Each requester port SHALL be, for n in {0,1}:
- reqn_RE input 1, line-read request.
- reqn_WE input 1, word-write request.
- reqn_A input 10, byte address; [9:2] is block, [1:0] is word_loc.
- reqn_WD input RISC_data, write word.
- reqn_done output 1, one-cycle completion pulse.
- reqn_err output 1, timeout flag, valid with reqn_done.
- reqn_RD output main_data, captured line.
REQ-004 Memory-side ports SHALL be:
- mem_RE output 1.
- mem_WE output 1.
- mem_A output 8, block address.
- mem_word_loc output 2.
- mem_WD output RISC_data.
- mem_done input 1.
- mem_RD input main_data.
REQ-005 Status ports SHALL be: busy output 1, high outside IDLE; grant output 2, one-hot owner, 00 in IDLE.

Function
REQ-006 FSM states SHALL be exactly IDLE, BUSY and DONE, with all outputs registered.
REQ-007 Requester handshake rules:
- A request SHALL be pending while reqn_RE or reqn_WE is high.
- The requester holds RE, WE, A and WD stable until it samples reqn_done high.
- The requester deasserts the request on that same edge.
REQ-008 In IDLE with any request pending, the arbiter SHALL latch the winner's op, A and WD, set grant, and enter BUSY on the next edge.
REQ-009 Arbitration SHALL be round-robin:
- A priority pointer selects the winner when both requesters are pending.
- The pointer resets to requester 0.
- In DONE the pointer moves to the requester not just served.
- A lone requester always wins, regardless of the pointer.
REQ-010 If both RE and WE are high on the winning port, the transaction SHALL be a write; RE is ignored.
REQ-011 In BUSY, mem_RE or mem_WE (exactly one) SHALL be held high, with mem_A = latched A[9:2], mem_word_loc = latched A[1:0] and mem_WD = latched WD.
REQ-012 In BUSY, on mem_done high:
- Strobes drop on that edge and the FSM enters DONE.
- For a read, mem_RD is captured into the owner's reqn_RD.
REQ-013 In DONE, for exactly one cycle: the owner's reqn_done = 1; then the FSM returns to IDLE with grant = 00.
REQ-014 Latency: a request sampled in IDLE at edge k SHALL drive the mem strobe from cycle k+1. A mem_done sampled at edge m SHALL produce reqn_done during cycle m+1. Back-to-back service SHALL begin no earlier than one IDLE cycle after DONE.
REQ-015 reqn_RD SHALL change only on a read capture for that requester; write transactions and the other requester's transactions leave it unchanged.
REQ-016 Timeout behaviour:
- A BUSY-cycle counter SHALL reset on entry to BUSY.
- If it reaches TIMEOUT-1 without mem_done, strobes drop and the FSM enters DONE.
- Only in that case, reqn_err = 1 with reqn_done; reqn_RD is not updated.
REQ-017 mem_done sampled in IDLE or DONE SHALL be ignored.
REQ-018 mem_done coincident with the timeout edge SHALL be treated as normal completion, with err = 0.
REQ-019 Request changes by the non-owner during BUSY or DONE SHALL have no effect until the next IDLE.

Reset
REQ-020 While RST is high at a clock edge, the block SHALL enter IDLE and clear all of the following: mem_RE, mem_WE, mem_A, mem_word_loc, mem_WD, reqn_done, reqn_err, reqn_RD, busy, grant, the timeout counter, and the priority pointer (pointer to 0).
REQ-021 RST asserted mid-transaction SHALL abort it with no done pulse issued; requesters re-request after reset.

Verification
REQ-022 Single read: req0_RE=1, A=10'h2C4; mem_done after 3 cycles with mem_RD=128'hA5..A5 -> mem_A=8'hB1, mem_RE high for 3 cycles, req0_done pulse one cycle later, req0_RD=128'hA5..A5, err=0.
REQ-023 Write: req1_WE=1, A=10'h00E, WD=32'hDEADBEEF -> mem_WE=1, mem_A=8'h03, mem_word_loc=2, mem_WD=32'hDEADBEEF; req1_done pulse; req1_RD unchanged.
REQ-024 Contention: req0 and req1 both pending out of reset, held after service -> grants alternate 01, 10, 01, 10 over four transactions.
REQ-025 Timeout: req0_RE=1, mem_done never asserted, TIMEOUT=64 -> mem_RE drops after 64 BUSY cycles; req0_done=1 and req0_err=1 for one cycle; req0_RD unchanged.
REQ-026 Reset in BUSY: RST pulsed on the 2nd BUSY cycle -> next cycle mem_RE=0, busy=0, grant=00; no done pulse; a late mem_done is ignored.
